bcd_counter_chain: RTL and testbench
====================================

# bcd_counter_chain

Parametrised multi-digit decade (BCD) counter built from positive-edge register stages with preset. It replaces hand-wired chains of single-bit flip-flops and single-digit counters. It provides up/down counting, synchronous preset and load, a cascade terminal-count output and a sticky wrap flag. It sits between the clock/enable source and the display decode logic, and chains to further instances through `tc`.

## Interface
Parameters:
- `DIGITS`, default 4: number of cascaded decade stages, minimum 1.

Ports:
- `c`, in, 1: clock; all state changes on the rising edge.
- `r`, in, 1: asynchronous, active-high reset.
- `p`, in, 1: synchronous preset.
- `ld`, in, 1: synchronous parallel load.
- `d`, in, 4*DIGITS: load value. Digit k is `d[4k+3:4k]`; digit 0 is least significant.
- `en`, in, 1: count enable, which is also the cascade carry-in.
- `dn`, in, 1: direction. 0 counts up, 1 counts down.
- `q`, out, 4*DIGITS: count value, same digit packing as `d`.
- `tc`, out, 1: terminal count, combinational, used for cascading.
- `ovf`, out, 1: sticky wrap flag, registered.
- `bad_ld`, out, 1: invalid-load pulse, registered.

## Operation
- **Priority:** `r` (async) > `p` > `ld` > `en` count > hold.
- **Reset (`r` = 1):**
  - Applies immediately, independent of `c`.
  - Clears `q` to all zeros and clears `ovf` and `bad_ld` to 0.
  - Holds these values while `r` is high.
- **Preset (`p` = 1):**
  - Every digit is set to 9.
  - `ovf` is cleared and `bad_ld` is set to 0.
- **Load (`ld` = 1, `p` = 0):**
  - Each digit takes its nibble from `d`.
  - Any nibble greater than 9 is loaded as 0 instead.
  - `bad_ld` is 1 for exactly that cycle if any nibble was greater than 9, otherwise 0.
  - `ovf` is cleared.
- **Count up (`en` = 1, `dn` = 0):**
  - Digit 0 increments.
  - Digit k increments only when all lower digits equal 9.
  - A digit at 9 that increments becomes 0.
- **Count down (`en` = 1, `dn` = 1):**
  - Digit 0 decrements.
  - Digit k decrements only when all lower digits equal 0.
  - A digit at 0 that decrements becomes 9.
- **Wrap:**
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - Either wrap sets `ovf` to 1, which stays set until `r`, `p` or `ld`.
- **Hold:** if `en` = 0 and no other control is active, `q` and `ovf` hold and `bad_ld` returns to 0.
- **`tc`:** `en & (dn ? q == all-0s : q == all-9s)`. Driving the next instance's `en` from `tc` gives an exact cascade.
- **BCD invariant:** `q` never holds a nibble greater than 9 after reset, load or counting.
- **`dn` changes:** take effect on the next enabled edge; there is no hidden direction state.

## Timing
- Count latency is one cycle: `q` updates on the rising edge after `en` is sampled high.
- `p` and `ld` also take effect on the next rising edge.
- `tc` reacts combinationally, in the same cycle, to `q`, `en` and `dn`. It has no registered delay, so cascaded instances count on the same edge.
- `ovf` sets on the same edge at which `q` wraps.
- `bad_ld` is high in the cycle after the offending load edge, for one cycle.
- **Reset:**
  - Asserting `r` mid-count forces zeros immediately.
  - On `r` deassertion, the first rising edge with `r` low applies normal priority.
- **Simultaneous controls:**
  - `p` with `ld` or `en`: preset wins, and the load and count are ignored.
  - `ld` with `en`: load wins, and no count occurs that cycle.
- **`DIGITS` = 1:** the block behaves as a single decade counter, and `tc` is the digit-0 terminal test.

## Structure
- **Shared package `bcd_pkg`:**
  - `DIGIT_W` = 4, `DIGIT_MAX` = 4'd9, `DIGIT_MIN` = 4'd0.
  - A function that validates a nibble (returns 1 if ≤ 9).
- **Sub-module `bcd_digit`:**
  - Ports: `c`, `r`, `p`, `ld`, `d[3:0]`, `ci`, `dn`, `q[3:0]`, `co`.
  - `co = ci & (dn ? q == 0 : q == 9)`.
  - The top level instantiates `DIGITS` copies in a generate loop, chaining each `co` to the next `ci`.
  - The top level owns `ovf`, `bad_ld` and the per-nibble load sanitisation.

## Test plan
- **Reset mid-count:**
  - Stimulus: count to 0x0347, assert `r` between edges.
  - Required: `q` = 0x0000, `ovf` = 0 and `bad_ld` = 0 before the next edge; values held while `r` is high.
- **Up carry chain:**
  - Stimulus: `ld` 0x0999, then 1 up count.
  - Required: `q` = 0x1000, `ovf` = 0, and `tc` high only while `q` = 0x9999 with `en` = 1.
- **Up wrap:**
  - Stimulus: `p`, then 1 up count.
  - Required: `q` goes 0x9999 then 0x0000, and `ovf` = 1 from that edge.
  - Then `ld` 0x0012: `ovf` = 0.
- **Down borrow and wrap:**
  - Stimulus: `ld` 0x1000, 1 down count; then `ld` 0x0000, 1 down count.
  - Required: `q` = 0x0999 after the first count; `q` = 0x9999 and `ovf` = 1 after the second.
- **Invalid load:**
  - Stimulus: `ld` with `d` = 0x3A5F.
  - Required: `q` = 0x3050, and `bad_ld` = 1 for exactly one cycle.
- **Priority:**
  - Stimulus: same edge with `p` = `ld` = `en` = 1 and `d` = 0x1234.
  - Required: `q` = 0x9999.
  - Stimulus: same edge with `ld` = `en` = 1.
  - Required: `q` = 0x1234, with no count applied.

Source files
------------

// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// Module   : bcd_pkg
// Purpose  : Shared digit constants and nibble validation for the BCD counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

    localparam int             DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd0;

    // Returns 1 when the nibble is a legal decimal digit.
    function automatic logic nibble_valid(input logic [DIGIT_W-1:0] n);
        return (n <= DIGIT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
//------------------------------------------------------------------------------
// Module   : bcd_digit
// Purpose  : Single decade up/down stage with preset, load and carry chaining.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit
    import bcd_pkg::*;
(
    input  logic               c,
    input  logic               r,
    input  logic               p,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] d,
    input  logic               ci,
    input  logic               dn,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    logic [DIGIT_W-1:0] r_q;

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_q <= DIGIT_MIN;
        end else if (p) begin
            r_q <= DIGIT_MAX;
        end else if (ld) begin
            r_q <= d;
        end else if (ci) begin
            if (dn)
                r_q <= (r_q == DIGIT_MIN) ? DIGIT_MAX : r_q - 4'd1;
            else
                r_q <= (r_q == DIGIT_MAX) ? DIGIT_MIN : r_q + 4'd1;
        end
    end

    assign q  = r_q;
    assign co = ci & (dn ? (r_q == DIGIT_MIN) : (r_q == DIGIT_MAX));

endmodule

`default_nettype wire

// File: rtl/bcd_counter_chain.sv
//------------------------------------------------------------------------------
// Module   : bcd_counter_chain
// Purpose  : Multi-digit cascadable BCD up/down counter with sticky wrap flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_counter_chain
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                   c,
    input  logic                   r,
    input  logic                   p,
    input  logic                   ld,
    input  logic [4*DIGITS-1:0]    d,
    input  logic                   en,
    input  logic                   dn,
    output logic [4*DIGITS-1:0]    q,
    output logic                   tc,
    output logic                   ovf,
    output logic                   bad_ld
);

    logic [DIGITS:0]       w_carry;
    logic [4*DIGITS-1:0]   w_ld_d;
    logic [DIGITS-1:0]     w_nib_bad;
    logic                  w_any_bad;
    logic                  r_ovf;
    logic                  r_bad_ld;

    assign w_carry[0] = en;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            // Illegal nibbles are replaced by zero so q stays BCD.
            assign w_nib_bad[k] = ~nibble_valid(d[4*k +: DIGIT_W]);
            assign w_ld_d[4*k +: DIGIT_W] = w_nib_bad[k] ? DIGIT_MIN : d[4*k +: DIGIT_W];

            bcd_digit u_digit (
                .c  (c),
                .r  (r),
                .p  (p),
                .ld (ld),
                .d  (w_ld_d[4*k +: DIGIT_W]),
                .ci (w_carry[k]),
                .dn (dn),
                .q  (q[4*k +: DIGIT_W]),
                .co (w_carry[k+1])
            );
        end
    endgenerate

    assign w_any_bad = |w_nib_bad;
    assign tc        = w_carry[DIGITS];

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_ovf    <= 1'b0;
            r_bad_ld <= 1'b0;
        end else if (p) begin
            r_ovf    <= 1'b0;
            r_bad_ld <= 1'b0;
        end else if (ld) begin
            r_ovf    <= 1'b0;
            r_bad_ld <= w_any_bad;
        end else begin
            // The last carry out is high exactly when the whole chain wraps.
            if (w_carry[DIGITS])
                r_ovf <= 1'b1;
            r_bad_ld <= 1'b0;
        end
    end

    assign ovf    = r_ovf;
    assign bad_ld = r_bad_ld;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_chain.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_counter_chain
// Purpose  : Self-checking bench for bcd_counter_chain with a scoreboard model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_counter_chain;

    localparam int DIGITS = 4;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic        ovf;
        logic        bad;
    } exp_t;

    logic        c = 1'b0;
    logic        r = 1'b1;
    logic        p = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] d = '0;
    logic        en = 1'b0;
    logic        dn = 1'b0;
    logic [15:0] q;
    logic        tc;
    logic        ovf;
    logic        bad_ld;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    logic [15:0] mq   = '0;
    logic        movf = 1'b0;
    logic        mbad = 1'b0;

    bcd_counter_chain #(.DIGITS(DIGITS)) dut (
        .c      (c),
        .r      (r),
        .p      (p),
        .ld     (ld),
        .d      (d),
        .en     (en),
        .dn     (dn),
        .q      (q),
        .tc     (tc),
        .ovf    (ovf),
        .bad_ld (bad_ld)
    );

    always #5 c = ~c;

    function automatic int from_bcd(input logic [15:0] b);
        int v = 0;
        for (int k = DIGITS - 1; k >= 0; k--)
            v = v * 10 + int'(b[4*k +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] res = '0;
        int          t   = v;
        for (int k = 0; k < DIGITS; k++) begin
            res[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return res;
    endfunction

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag; e.q = mq; e.ovf = movf; e.bad = mbad;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        assert ({q, ovf, bad_ld} === {e.q, e.ovf, e.bad}) else begin
            n_fail++;
            $error("FAIL %s: observed q=%h ovf=%b bad_ld=%b expected q=%h ovf=%b bad_ld=%b",
                   e.tag, q, ovf, bad_ld, e.q, e.ovf, e.bad);
        end
    endtask

    task automatic check_tc(input string tag, input logic exp);
        n_assert++;
        assert (tc === exp) else begin
            n_fail++;
            $error("FAIL %s: observed tc=%b expected tc=%b", tag, tc, exp);
        end
    endtask

    task automatic expect_q(input string tag, input logic [15:0] v);
        n_assert++;
        assert (q === v) else begin
            n_fail++;
            $error("FAIL %s: observed q=%h expected q=%h", tag, q, v);
        end
    endtask

    // One clocked step: drive at negedge, check tc, predict, compare after edge.
    task automatic cyc(input string tag, input logic i_p, input logic i_ld,
                       input logic [15:0] i_d, input logic i_en, input logic i_dn);
        logic exp_tc;
        logic any_bad;
        logic [15:0] nd;
        int v;
        @(negedge c);
        p = i_p; ld = i_ld; d = i_d; en = i_en; dn = i_dn;
        exp_tc = i_en && (i_dn ? (mq == 16'h0000) : (mq == 16'h9999));
        #1 check_tc({tag, "_tc"}, exp_tc);
        if (i_p) begin
            mq = 16'h9999; movf = 1'b0; mbad = 1'b0;
        end else if (i_ld) begin
            any_bad = 1'b0;
            nd = i_d;
            for (int k = 0; k < DIGITS; k++) begin
                if (nd[4*k +: 4] > 4'd9) begin
                    nd[4*k +: 4] = 4'd0;
                    any_bad = 1'b1;
                end
            end
            mq = nd; movf = 1'b0; mbad = any_bad;
        end else if (i_en) begin
            v = from_bcd(mq);
            v = i_dn ? (v + 9999) % 10000 : (v + 1) % 10000;
            if (exp_tc) movf = 1'b1;
            mq = to_bcd(v); mbad = 1'b0;
        end else begin
            mbad = 1'b0;
        end
        push(tag);
        @(posedge c);
        #1 check_out();
    endtask

    initial begin
        // Reset state while r is high from time zero.
        #2;
        mq = '0; movf = 1'b0; mbad = 1'b0;
        push("reset_init");
        check_out();
        @(negedge c);
        r = 1'b0;

        // Count up to 0347, then assert reset between edges.
        cyc("ld_0340", 1'b0, 1'b1, 16'h0340, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            cyc("up_to_0347", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        expect_q("at_0347", 16'h0347);
        @(negedge c);
        en = 1'b1; dn = 1'b0;
        #2 r = 1'b1;
        mq = '0; movf = 1'b0; mbad = 1'b0;
        #1 push("reset_async");
        check_out();
        @(posedge c);
        #1 push("reset_hold");
        check_out();
        @(negedge c);
        r = 1'b0; en = 1'b0;

        // Up carry chain.
        cyc("ld_0999", 1'b0, 1'b1, 16'h0999, 1'b0, 1'b0);
        cyc("up_carry", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        expect_q("carry_1000", 16'h1000);

        // Up wrap from preset, sticky ovf, cleared by load.
        cyc("preset", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc("hold_9999_no_en", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc("up_wrap", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        expect_q("wrap_0000", 16'h0000);
        cyc("ovf_sticky", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc("up_after_wrap", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cyc("ld_0012", 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);

        // Down borrow and down wrap.
        cyc("ld_1000", 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        cyc("dn_borrow", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        expect_q("borrow_0999", 16'h0999);
        cyc("ld_0000", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc("dn_wrap", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        expect_q("dn_wrap_9999", 16'h9999);

        // Invalid load: bad_ld for exactly one cycle.
        cyc("ld_3A5F", 1'b0, 1'b1, 16'h3A5F, 1'b0, 1'b0);
        expect_q("sanitised_3050", 16'h3050);
        cyc("bad_clear", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Priority: preset over load/count, load over count.
        cyc("p_ld_en", 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
        expect_q("prio_9999", 16'h9999);
        cyc("ld_en", 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        expect_q("prio_1234", 16'h1234);

        // Direction changes between enabled edges.
        cyc("dir_up", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cyc("dir_dn", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        cyc("dir_dn2", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        cyc("hold_dn", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        expect_q("dir_1233", 16'h1233);

        if (sb.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
